home_event_sched: RTL and testbench
===================================

HOME_EVENT_SCHED -- requirements
Module: home_event_sched

Interface
REQ-001 The block SHALL have parameter HOLD_CYC, default 8, giving actuator on-time in cycles after a grant (legal range 1..15).
REQ-002 The block SHALL have parameter T_HOT, default 7'd50, the temperature at or above which a hot event is raised.
REQ-003 The block SHALL have parameter T_COLD, default 7'd15, the temperature at or below which a cold event is raised.
REQ-004 The block SHALL have port Clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have ports SFD, SRD, SW and SFA, each input, 1 bit: front-door, rear-door, window and fire-alarm sensor levels.
REQ-007 The block SHALL have port ST, input, 7 bits: unsigned temperature.
REQ-008 The block SHALL have port evt_valid, output, 1 bit: an event offer to the downstream annunciator.
REQ-009 The block SHALL have port evt_ready, input, 1 bit: the downstream accept signal.
REQ-010 The block SHALL have ports fdoor, rdoor, winbuzz, alarmbuzz, heater and cooler, each output, 1 bit: actuator enables.
REQ-011 The block SHALL have port display, output, 3 bits: the current event code.

Function
REQ-012 The event codes SHALL be 0 idle, 1 fire, 2 front door, 3 rear door, 4 window, 5 hot, 6 cold.
REQ-013 Condition levels SHALL be registered every cycle: hot = ST>=T_HOT; cold = ST<=T_COLD.
REQ-014 A pending bit per event SHALL set on a 0->1 edge of its registered condition.
REQ-015 A level held high SHALL raise only one request.
REQ-016 A pending bit SHALL clear on handshake transfer of its code.
REQ-017 If a set and a clear of the same pending bit occur in one cycle, the set SHALL win.
REQ-018 Arbitration priority SHALL be fixed, highest first: fire > front door > rear door > window > hot > cold.
REQ-019 FSM state IDLE SHALL hold evt_valid=0 and display=0; with any pending bit set, the next state SHALL be OFFER, latching the highest-priority code.
REQ-020 In FSM state OFFER, evt_valid SHALL be 1 and display SHALL equal the latched code; the code SHALL stay stable until evt_valid && evt_ready, and a transfer SHALL go to HOLD with the counter loaded to HOLD_CYC-1.
REQ-021 In FSM state HOLD, the actuator for the code SHALL be asserted (fire->alarmbuzz, 2->fdoor, 3->rdoor, 4->winbuzz, 5->cooler, 6->heater); the counter SHALL decrement each cycle; at 0 the next state SHALL be IDLE, or OFFER if a pending bit is set.
REQ-022 HOLD duration SHALL be exactly HOLD_CYC cycles.
REQ-023 Fire preemption: fire pending while in HOLD with a non-fire code SHALL drop the actuator and go to OFFER with code 1 on the next edge.
REQ-024 An event whose HOLD is aborted by preemption SHALL NOT be re-queued.
REQ-025 In OFFER, a lower-priority code SHALL NOT be replaced by fire before transfer.
REQ-026 At most one actuator output SHALL be high in any cycle; heater and cooler SHALL never be high together.
REQ-027 evt_valid SHALL be 1 only in OFFER; display SHALL equal 0 in IDLE.
REQ-028 Temperature compares SHALL be unsigned 7-bit; the counter SHALL be 4 bits and SHALL NOT wrap below 0.

Reset
REQ-029 On Rst_n=0 the block SHALL immediately force the FSM to IDLE and clear the counter, all pending bits and the condition registers.
REQ-030 On Rst_n=0 the outputs SHALL be evt_valid=0, display=0 and all actuators 0.
REQ-031 Reset asserted mid-OFFER or mid-HOLD SHALL discard the event.
REQ-032 A sensor already high at reset release SHALL raise a request on the first cycle after release, because the condition register resets to 0.

Structure
REQ-033 Event code enum, priority order and default T_HOT/T_COLD/HOLD_CYC SHALL live in shared package home_pkg.
REQ-034 Fixed-priority selection SHALL be sub-module home_prio_enc (6-bit pending in, valid plus 3-bit code out).

Verification
REQ-035 The bench SHALL drive SW 0->1 with evt_ready=1 and SHALL check evt_valid and display=4, then winbuzz high for exactly 8 cycles, then IDLE, with no second request while SW stays high.
REQ-036 The bench SHALL raise SFD and SW in the same cycle and SHALL check the order: code 2 served first, then code 4 after its HOLD.
REQ-037 The bench SHALL raise SFA during HOLD of code 4 (cycle 3) and SHALL check winbuzz drops next edge, OFFER code 1, alarmbuzz for 8 cycles, and code 4 not re-offered.
REQ-038 The bench SHALL hold evt_ready=0 for 5 cycles with code 3 offered and raise SFA meanwhile; it SHALL check display stays 3 and evt_valid stays 1 until accept, then fire is offered after that HOLD.
REQ-039 The bench SHALL set ST=60 then ST=10 and check cooler then heater, never both; ST=30 SHALL raise no temperature event.
REQ-040 The bench SHALL assert Rst_n=0 asynchronously mid-HOLD and SHALL check all outputs 0 before the next Clk edge; with SFD held high through release it SHALL check code 2 offered 2 cycles after release.

Source files
------------

// File: rtl/home_pkg.sv
`default_nettype none
// ============================================================================
// Module      : home_pkg
// Description : Shared event codes, priority bit layout and default parameters
//               for the home event scheduler.
// Revision    : 1.0
// ============================================================================
package home_pkg;

    localparam int         HOLD_CYC_DEF = 8;
    localparam logic [6:0] T_HOT_DEF    = 7'd50;
    localparam logic [6:0] T_COLD_DEF   = 7'd15;
    localparam int         N_EVT        = 6;

    // Pending bit i carries code i+1; a lower index means higher priority.
    localparam int P_FIRE  = 0;
    localparam int P_FDOOR = 1;
    localparam int P_RDOOR = 2;
    localparam int P_WIN   = 3;
    localparam int P_HOT   = 4;
    localparam int P_COLD  = 5;

    typedef enum logic [2:0] {
        EVT_IDLE  = 3'd0,
        EVT_FIRE  = 3'd1,
        EVT_FDOOR = 3'd2,
        EVT_RDOOR = 3'd3,
        EVT_WIN   = 3'd4,
        EVT_HOT   = 3'd5,
        EVT_COLD  = 3'd6
    } evt_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic [N_EVT-1:0] code_mask(input evt_code_t c);
        logic [N_EVT-1:0] m;
        m = '0;
        case (c)
            EVT_FIRE:  m[P_FIRE]  = 1'b1;
            EVT_FDOOR: m[P_FDOOR] = 1'b1;
            EVT_RDOOR: m[P_RDOOR] = 1'b1;
            EVT_WIN:   m[P_WIN]   = 1'b1;
            EVT_HOT:   m[P_HOT]   = 1'b1;
            EVT_COLD:  m[P_COLD]  = 1'b1;
            default:   m = '0;
        endcase
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/home_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : home_prio_enc
// Description : Fixed-priority encoder; lowest set pending bit wins.
// Revision    : 1.0
// ============================================================================
module home_prio_enc
    import home_pkg::*;
(
    input  logic [N_EVT-1:0] i_pend,
    output logic             o_valid,
    output evt_code_t        o_code
);

    always_comb begin
        o_code = EVT_IDLE;
        for (int i = N_EVT - 1; i >= 0; i--) begin
            if (i_pend[i]) begin
                o_code = evt_code_t'(3'(i + 1));
            end
        end
    end

    assign o_valid = |i_pend;

endmodule
`default_nettype wire

// File: rtl/home_event_sched.sv
`default_nettype none
// ============================================================================
// Module      : home_event_sched
// Description : Edge-triggered home sensor events, priority-offered downstream,
//               each driving its actuator for HOLD_CYC cycles after accept.
// Revision    : 1.0
// ============================================================================
module home_event_sched
    import home_pkg::*;
#(
    parameter int         HOLD_CYC = HOLD_CYC_DEF,
    parameter logic [6:0] T_HOT    = T_HOT_DEF,
    parameter logic [6:0] T_COLD   = T_COLD_DEF
)(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       SFD,
    input  logic       SRD,
    input  logic       SW,
    input  logic       SFA,
    input  logic [6:0] ST,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic       fdoor,
    output logic       rdoor,
    output logic       winbuzz,
    output logic       alarmbuzz,
    output logic       heater,
    output logic       cooler,
    output logic [2:0] display
);

    state_t           r_state, w_state_nxt;
    evt_code_t        r_code, w_code_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [N_EVT-1:0] r_cond, r_pend;
    logic [N_EVT-1:0] w_cond, w_set, w_clr;
    logic             w_enc_valid;
    evt_code_t        w_enc_code;
    logic             w_xfer;

    always_comb begin
        w_cond          = '0;
        w_cond[P_FIRE]  = SFA;
        w_cond[P_FDOOR] = SFD;
        w_cond[P_RDOOR] = SRD;
        w_cond[P_WIN]   = SW;
        w_cond[P_HOT]   = (ST >= T_HOT);
        w_cond[P_COLD]  = (ST <= T_COLD);
    end

    assign w_xfer = (r_state == ST_OFFER) && evt_ready;
    assign w_set  = w_cond & ~r_cond;
    assign w_clr  = w_xfer ? code_mask(r_code) : '0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_cond <= '0;
            r_pend <= '0;
        end else begin
            r_cond <= w_cond;
            // set applied after clear so a coincident new edge survives
            r_pend <= (r_pend & ~w_clr) | w_set;
        end
    end

    home_prio_enc u_prio (
        .i_pend  (r_pend),
        .o_valid (w_enc_valid),
        .o_code  (w_enc_code)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_code  <= EVT_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_enc_valid) begin
                    w_state_nxt = ST_OFFER;
                    w_code_nxt  = w_enc_code;
                end
            end
            ST_OFFER: begin
                if (evt_ready) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = 4'(HOLD_CYC - 1);
                end
            end
            ST_HOLD: begin
                if (r_pend[P_FIRE] && (r_code != EVT_FIRE)) begin
                    w_state_nxt = ST_OFFER;
                    w_code_nxt  = EVT_FIRE;
                end else if (r_cnt == 4'd0) begin
                    if (w_enc_valid) begin
                        w_state_nxt = ST_OFFER;
                        w_code_nxt  = w_enc_code;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign evt_valid = (r_state == ST_OFFER);
    assign display   = (r_state == ST_IDLE) ? 3'd0 : r_code;
    assign alarmbuzz = (r_state == ST_HOLD) && (r_code == EVT_FIRE);
    assign fdoor     = (r_state == ST_HOLD) && (r_code == EVT_FDOOR);
    assign rdoor     = (r_state == ST_HOLD) && (r_code == EVT_RDOOR);
    assign winbuzz   = (r_state == ST_HOLD) && (r_code == EVT_WIN);
    assign cooler    = (r_state == ST_HOLD) && (r_code == EVT_HOT);
    assign heater    = (r_state == ST_HOLD) && (r_code == EVT_COLD);

endmodule
`default_nettype wire

// File: tb/tb_home_event_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_home_event_sched
// Description : Directed bench for home_event_sched with hand-computed vectors.
// Revision    : 1.0
// ============================================================================
module tb_home_event_sched;

    logic       Clk, Rst_n;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       evt_valid, evt_ready;
    logic       fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler;
    logic [2:0] display;

    int tests = 0;
    int fails = 0;

    // actuator vector order: {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler}
    localparam logic [5:0] A_NONE = 6'b000000;
    localparam logic [5:0] A_FD   = 6'b100000;
    localparam logic [5:0] A_RD   = 6'b010000;
    localparam logic [5:0] A_WB   = 6'b001000;
    localparam logic [5:0] A_AB   = 6'b000100;
    localparam logic [5:0] A_HT   = 6'b000010;
    localparam logic [5:0] A_CL   = 6'b000001;
    localparam logic [9:0] V_IDLE = 10'd0;

    home_event_sched dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .SFD       (SFD),
        .SRD       (SRD),
        .SW        (SW),
        .SFA       (SFA),
        .ST        (ST),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .fdoor     (fdoor),
        .rdoor     (rdoor),
        .winbuzz   (winbuzz),
        .alarmbuzz (alarmbuzz),
        .heater    (heater),
        .cooler    (cooler),
        .display   (display)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [9:0] ev(input logic v, input logic [2:0] d, input logic [5:0] a);
        return {v, d, a};
    endfunction

    function automatic logic [9:0] obs();
        return {evt_valid, display, fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler};
    endfunction

    task automatic chk(input string tag, input logic [9:0] exp);
        logic [9:0] o;
        o = obs();
        tests++;
        assert (o === exp) else begin
            fails++;
            $error("FAIL %s: observed {v,disp,act}=%b_%03b_%06b expected %b_%03b_%06b",
                   tag, o[9], o[8:6], o[5:0], exp[9], exp[8:6], exp[5:0]);
        end
    endtask

    task automatic expect_n(input string tag, input logic [9:0] exp, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            chk(tag, exp);
        end
    endtask

    // mutual exclusion of actuators checked every cycle
    always @(negedge Clk) begin
        tests++;
        assert (($countones({fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler}) <= 1)
                && !(heater && cooler)) else begin
            fails++;
            $error("FAIL act_onehot: observed act=%06b expected at most one high",
                   {fdoor, rdoor, winbuzz, alarmbuzz, heater, cooler});
        end
    end

    initial begin
        Rst_n = 1'b0; SFD = 1'b0; SRD = 1'b0; SW = 1'b0; SFA = 1'b0;
        ST = 7'd30; evt_ready = 1'b1;

        #3 chk("reset_async", V_IDLE);
        @(negedge Clk);
        chk("reset_held", V_IDLE);
        #1 Rst_n = 1'b1;
        expect_n("post_reset_idle", V_IDLE, 2);

        // window event, single request while level stays high
        SW = 1'b1;
        expect_n("s1_pend",  V_IDLE, 1);
        expect_n("s1_offer", ev(1'b1, 3'd4, A_NONE), 1);
        expect_n("s1_hold",  ev(1'b0, 3'd4, A_WB), 8);
        expect_n("s1_idle",  V_IDLE, 4);
        SW = 1'b0;
        expect_n("s2_pre", V_IDLE, 2);

        // simultaneous front door and window: priority order
        SFD = 1'b1; SW = 1'b1;
        expect_n("s2_pend",   V_IDLE, 1);
        expect_n("s2_offer2", ev(1'b1, 3'd2, A_NONE), 1);
        expect_n("s2_hold2",  ev(1'b0, 3'd2, A_FD), 8);
        expect_n("s2_offer4", ev(1'b1, 3'd4, A_NONE), 1);
        expect_n("s2_hold4",  ev(1'b0, 3'd4, A_WB), 8);
        expect_n("s2_idle",   V_IDLE, 2);
        SFD = 1'b0; SW = 1'b0;
        expect_n("s3_pre", V_IDLE, 2);

        // fire preempts window hold in its third cycle
        SW = 1'b1;
        expect_n("s3_pend",   V_IDLE, 1);
        expect_n("s3_offer4", ev(1'b1, 3'd4, A_NONE), 1);
        expect_n("s3_hold4",  ev(1'b0, 3'd4, A_WB), 3);
        SFA = 1'b1;
        expect_n("s3_hold4_late", ev(1'b0, 3'd4, A_WB), 1);
        expect_n("s3_offer1",     ev(1'b1, 3'd1, A_NONE), 1);
        expect_n("s3_hold1",      ev(1'b0, 3'd1, A_AB), 8);
        expect_n("s3_no_requeue", V_IDLE, 4);
        SFA = 1'b0; SW = 1'b0;
        expect_n("s4_pre", V_IDLE, 2);

        // back-pressure: code 3 stays offered, fire waits for the transfer
        evt_ready = 1'b0;
        SRD = 1'b1;
        expect_n("s4_pend",   V_IDLE, 1);
        expect_n("s4_offer3", ev(1'b1, 3'd3, A_NONE), 1);
        SFA = 1'b1;
        expect_n("s4_offer3_stall", ev(1'b1, 3'd3, A_NONE), 4);
        evt_ready = 1'b1;
        expect_n("s4_hold3",  ev(1'b0, 3'd3, A_RD), 1);
        expect_n("s4_offer1", ev(1'b1, 3'd1, A_NONE), 1);
        expect_n("s4_hold1",  ev(1'b0, 3'd1, A_AB), 8);
        expect_n("s4_idle",   V_IDLE, 3);
        SFA = 1'b0; SRD = 1'b0;
        expect_n("s5_pre", V_IDLE, 2);

        // temperature: hot, then cold, then mid-range
        ST = 7'd60;
        expect_n("s5_hot_pend",  V_IDLE, 1);
        expect_n("s5_hot_offer", ev(1'b1, 3'd5, A_NONE), 1);
        expect_n("s5_cooler",    ev(1'b0, 3'd5, A_CL), 8);
        expect_n("s5_hot_idle",  V_IDLE, 2);
        ST = 7'd10;
        expect_n("s5_cold_pend",  V_IDLE, 1);
        expect_n("s5_cold_offer", ev(1'b1, 3'd6, A_NONE), 1);
        expect_n("s5_heater",     ev(1'b0, 3'd6, A_HT), 8);
        expect_n("s5_cold_idle",  V_IDLE, 2);
        ST = 7'd30;
        expect_n("s5_mid_none", V_IDLE, 4);

        // asynchronous reset mid-hold, front door held through release
        SFD = 1'b1;
        expect_n("s6_pend",   V_IDLE, 1);
        expect_n("s6_offer2", ev(1'b1, 3'd2, A_NONE), 1);
        expect_n("s6_hold2",  ev(1'b0, 3'd2, A_FD), 2);
        #2 Rst_n = 1'b0;
        #1 chk("s6_rst_async", V_IDLE);
        @(negedge Clk);
        chk("s6_rst_held", V_IDLE);
        #1 Rst_n = 1'b1;
        expect_n("s6_rel_pend",  V_IDLE, 1);
        expect_n("s6_rel_offer", ev(1'b1, 3'd2, A_NONE), 1);
        expect_n("s6_rel_hold",  ev(1'b0, 3'd2, A_FD), 8);
        expect_n("s6_rel_idle",  V_IDLE, 2);
        SFD = 1'b0;
        expect_n("end_idle", V_IDLE, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
